// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants and types for the decode register file and its
// pending-write scoreboard.
package reg_file_scoreboard_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

endpackage

// File: rtl/reg_file_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
// err_o pulses when an increment hits the ceiling or a decrement hits zero.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);
  import reg_file_scoreboard_pkg::*;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  cnt_op_e          op;

  always_comb begin
    op = CNT_HOLD;
    if (inc_i && !dec_i)      op = CNT_INC;
    else if (dec_i && !inc_i) op = CNT_DEC;

    cnt_d = cnt_q;
    err_o = 1'b0;
    unique case (op)
      CNT_INC: begin
        if (cnt_q == '1) err_o = 1'b1;
        else             cnt_d = cnt_q + 1'b1;
      end
      CNT_DEC: begin
        if (cnt_q == '0) err_o = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// 32x32 architectural register file with write-through bypass and a
// per-register pending-write scoreboard that stalls decode on RAW hazards.
module reg_file_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              reg_WBack,
  input  logic [ADDR_W-1:0] rd_WBack,
  input  logic [DATA_W-1:0] data_WBack,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              hazard_stall,
  output logic              sb_error
);
  import reg_file_scoreboard_pkg::*;

  localparam int unsigned NREG = 2**ADDR_W;

  logic [DATA_W-1:0]           regs_q [NREG];
  logic [NREG-1:0][CNT_W-1:0]  cnt;
  logic [NREG-1:0]             wb_hit, busy, cnt_err;
  logic                        issue_ok;
  logic                        err_q, err_d;

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      wb_hit[i] = reg_WBack && (rd_WBack == ADDR_W'(i)) && (i != 0);
      // A single outstanding write retiring this cycle is covered by the bypass
      busy[i]   = (cnt[i] > CNT_W'(1)) || ((cnt[i] == CNT_W'(1)) && !wb_hit[i]);
    end
  end

  assign hazard_stall = (rs_used && busy[rs_addr]) || (rt_used && busy[rt_addr]);
  assign issue_ok     = issue_valid && issue_wr && !hazard_stall && (issue_rd != REG_ZERO);

  assign cnt[0]     = '0;
  assign cnt_err[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clock),
      .rst_i (aclr),
      .inc_i (issue_ok && (issue_rd == ADDR_W'(g))),
      .dec_i (wb_hit[g]),
      .cnt_o (cnt[g]),
      .err_o (cnt_err[g])
    );
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (reg_WBack && (rd_WBack != REG_ZERO)) begin
      regs_q[rd_WBack] <= data_WBack;
    end
  end

  always_comb begin
    rs_data = '0;
    if (rs_addr != REG_ZERO)
      rs_data = (reg_WBack && (rd_WBack == rs_addr)) ? data_WBack : regs_q[rs_addr];
    rt_data = '0;
    if (rt_addr != REG_ZERO)
      rt_data = (reg_WBack && (rd_WBack == rt_addr)) ? data_WBack : regs_q[rt_addr];
  end

  assign err_d = err_q || (|cnt_err);

  always_ff @(posedge clock) begin
    if (aclr) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign sb_error = err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed vector table followed by randomized traffic checked against an
// array-based model of the register file and pending-write counts.
module tb_reg_file_scoreboard;

  logic        clock = 1'b0;
  logic        aclr, reg_WBack, rs_used, rt_used, issue_valid, issue_wr;
  logic [4:0]  rd_WBack, rs_addr, rt_addr, issue_rd;
  logic [31:0] data_WBack, rs_data, rt_data;
  logic        hazard_stall, sb_error;

  always #5 clock = ~clock;

  reg_file_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clock        (clock),
    .aclr         (aclr),
    .reg_WBack    (reg_WBack),
    .rd_WBack     (rd_WBack),
    .data_WBack   (data_WBack),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_rd     (issue_rd),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .hazard_stall (hazard_stall),
    .sb_error     (sb_error)
  );

  typedef struct {
    logic        rst, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rs, rt;
    logic        ru, tu, iv, iw;
    logic [4:0]  ird;
    logic [31:0] ers, ert;
    logic        est, eerr, chk;
  } vec_t;

  localparam int unsigned NVEC = 35;
  vec_t tbl [NVEC];

  logic [31:0] m_reg [32];
  int unsigned m_cnt [32];
  logic        m_err;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  function automatic vec_t mkv(input int unsigned rst, we, wa, wd, rs, rt, ru, tu,
                               iv, iw, ird, ers, ert, est, eerr, chk);
    vec_t v;
    v.rst = 1'(rst); v.we = 1'(we); v.wa = 5'(wa); v.wd = wd;
    v.rs = 5'(rs); v.rt = 5'(rt); v.ru = 1'(ru); v.tu = 1'(tu);
    v.iv = 1'(iv); v.iw = 1'(iw); v.ird = 5'(ird);
    v.ers = ers; v.ert = ert; v.est = 1'(est); v.eerr = 1'(eerr); v.chk = 1'(chk);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model, written from the architectural rules
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (reg_WBack && rd_WBack == a) return data_WBack;
    return m_reg[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    logic hit;
    if (a == 5'd0) return 1'b0;
    hit = reg_WBack && rd_WBack == a;
    return (m_cnt[a] > 1) || (m_cnt[a] == 1 && !hit);
  endfunction

  function automatic logic m_stall();
    return (rs_used && m_busy(rs_addr)) || (rt_used && m_busy(rt_addr));
  endfunction

  task automatic m_clock();
    logic acc, hit, iss;
    if (aclr) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 32'd0; m_cnt[i] = 0; end
      m_err = 1'b0;
      return;
    end
    acc = issue_valid && issue_wr && !m_stall() && issue_rd != 5'd0;
    for (int i = 1; i < 32; i++) begin
      hit = reg_WBack && rd_WBack == 5'(i);
      iss = acc && issue_rd == 5'(i);
      if (iss && !hit) begin
        if (m_cnt[i] == 3) m_err = 1'b1; else m_cnt[i]++;
      end else if (hit && !iss) begin
        if (m_cnt[i] == 0) m_err = 1'b1; else m_cnt[i]--;
      end
    end
    if (reg_WBack && rd_WBack != 5'd0) m_reg[rd_WBack] = data_WBack;
  endtask

  task automatic drive(input vec_t v);
    aclr = v.rst; reg_WBack = v.we; rd_WBack = v.wa; data_WBack = v.wd;
    rs_addr = v.rs; rt_addr = v.rt; rs_used = v.ru; rt_used = v.tu;
    issue_valid = v.iv; issue_wr = v.iw; issue_rd = v.ird;
  endtask

  task automatic finish_cycle();
    @(posedge clock);
    m_clock();
    @(negedge clock);
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_reg[i] = 32'd0; m_cnt[i] = 0; end
    m_err = 1'b0;
    //               rst we wa wd          rs rt ru tu iv iw ird  ers         ert  st er chk
    tbl[0]  = mkv(1, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0,  0,          0,   0, 0, 0);
    tbl[1]  = mkv(0, 0, 0, 0,           5, 0, 1, 1, 0, 0, 0,  0,          0,   0, 0, 1);
    tbl[2]  = mkv(0, 0, 0, 0,           0, 0, 0, 0, 1, 1, 7,  0,          0,   0, 0, 1);
    tbl[3]  = mkv(0, 1, 7, 32'hDEADBEEF,7, 0, 1, 0, 0, 0, 0,  32'hDEADBEEF,0,  0, 0, 1);
    tbl[4]  = mkv(0, 0, 0, 0,           7, 0, 1, 1, 0, 0, 0,  32'hDEADBEEF,0,  0, 0, 1);
    tbl[5]  = mkv(0, 1, 0, 32'h1234,    7, 0, 1, 1, 0, 0, 0,  32'hDEADBEEF,0,  0, 0, 1);
    tbl[6]  = mkv(0, 0, 0, 0,           0, 0, 1, 1, 0, 0, 0,  0,          0,   0, 0, 1);
    tbl[7]  = mkv(0, 0, 0, 0,           0, 0, 0, 0, 1, 1, 3,  0,          0,   0, 0, 1);
    tbl[8]  = mkv(0, 1, 3, 32'h11,      3, 0, 1, 0, 1, 1, 3,  32'h11,     0,   0, 0, 1);
    tbl[9]  = mkv(0, 0, 0, 0,           3, 3, 0, 0, 0, 0, 0,  32'h11,     32'h11, 0, 0, 1);
    tbl[10] = mkv(0, 1, 3, 32'h22,      3, 0, 1, 0, 0, 0, 0,  32'h22,     0,   0, 0, 1);
    tbl[11] = mkv(0, 0, 0, 0,           3, 3, 1, 1, 0, 0, 0,  32'h22,     32'h22, 0, 0, 1);
    tbl[12] = mkv(0, 0, 0, 0,           0, 0, 0, 0, 1, 1, 9,  0,          0,   0, 0, 1);
    tbl[13] = mkv(0, 0, 0, 0,           9, 0, 1, 0, 1, 1, 9,  0,          0,   1, 0, 1);
    tbl[14] = mkv(0, 0, 0, 0,           9, 9, 0, 0, 0, 0, 0,  0,          0,   0, 0, 1);
    tbl[15] = mkv(0, 1, 9, 32'h55,      9, 0, 1, 0, 0, 0, 0,  32'h55,     0,   0, 0, 1);
    tbl[16] = mkv(0, 0, 0, 0,           9, 9, 1, 1, 0, 0, 0,  32'h55,     32'h55, 0, 0, 1);
    tbl[17] = mkv(0, 0, 0, 0,           0, 0, 0, 0, 1, 1, 4,  0,          0,   0, 0, 1);
    tbl[18] = tbl[17];
    tbl[19] = tbl[17];
    tbl[20] = mkv(0, 1, 4, 32'hA,       0, 4, 0, 1, 0, 0, 0,  0,          32'hA, 1, 0, 1);
    tbl[21] = mkv(0, 0, 0, 0,           0, 4, 0, 1, 0, 0, 0,  0,          32'hA, 1, 0, 1);
    tbl[22] = tbl[17];
    tbl[23] = tbl[17];
    tbl[24] = mkv(0, 0, 0, 0,           0, 4, 0, 1, 0, 0, 0,  0,          32'hA, 1, 1, 1);
    tbl[25] = mkv(1, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0,  0,          0,   0, 1, 1);
    tbl[26] = mkv(0, 1, 6, 32'h66,      6, 0, 1, 0, 0, 0, 0,  32'h66,     0,   0, 0, 1);
    tbl[27] = mkv(0, 0, 0, 0,           6, 0, 1, 0, 0, 0, 0,  32'h66,     0,   0, 1, 1);
    tbl[28] = mkv(1, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0,  0,          0,   0, 1, 1);
    tbl[29] = mkv(0, 0, 0, 0,           6, 4, 1, 1, 0, 0, 0,  0,          0,   0, 0, 1);
    tbl[30] = mkv(0, 0, 0, 0,           0, 0, 0, 0, 1, 1, 12, 0,          0,   0, 0, 1);
    tbl[31] = mkv(0, 1, 12, 32'h77,     12, 0, 1, 0, 1, 1, 12, 32'h77,    0,   0, 0, 1);
    tbl[32] = mkv(0, 0, 0, 0,           12, 0, 1, 0, 0, 0, 0, 32'h77,     0,   1, 0, 1);
    tbl[33] = mkv(1, 1, 12, 32'h88,     12, 0, 1, 0, 1, 1, 12, 32'h88,    0,   0, 0, 1);
    tbl[34] = mkv(0, 0, 0, 0,           12, 12, 1, 1, 0, 0, 0, 0,         0,   0, 0, 1);

    drive(tbl[0]);
    @(negedge clock);
    for (int k = 0; k < int'(NVEC); k++) begin
      drive(tbl[k]);
      #1;
      if (tbl[k].chk) begin
        check($sformatf("vec%0d rs_data", k), rs_data, tbl[k].ers);
        check($sformatf("vec%0d rt_data", k), rt_data, tbl[k].ert);
        check($sformatf("vec%0d hazard_stall", k), 32'(hazard_stall), 32'(tbl[k].est));
        check($sformatf("vec%0d sb_error", k), 32'(sb_error), 32'(tbl[k].eerr));
      end
      finish_cycle();
    end

    for (int n = 0; n < 3000; n++) begin
      aclr        = ($urandom_range(0, 59) == 0);
      reg_WBack   = 1'($urandom_range(0, 1));
      rd_WBack    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      data_WBack  = $urandom;
      rs_addr     = 5'($urandom_range(0, 7));
      rt_addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs_used     = 1'($urandom_range(0, 1));
      rt_used     = 1'($urandom_range(0, 1));
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wr    = ($urandom_range(0, 3) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      #1;
      check("rand rs_data", rs_data, m_read(rs_addr));
      check("rand rt_data", rt_data, m_read(rt_addr));
      check("rand hazard_stall", 32'(hazard_stall), 32'(m_stall()));
      check("rand sb_error", 32'(sb_error), 32'(m_err));
      finish_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
